uart_tx_sched: RTL

Transmit scheduler placed in front of the byte-wide UART transmitter. It arbitrates byte requests from NUM_REQ clients using round-robin and buffers accepted bytes in a FIFO. It paces single-cycle write strobes to the UART so that no strobe lands while a frame is still in flight. The UART exposes no busy flag, so this block owns the frame timing.

---
 rtl/uart_pkg.sv | 14 +
 rtl/sync_fifo.sv | 59 +++++
 rtl/uart_tx_sched.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transmit path.
package uart_pkg;

    localparam int BYTE_W               = 8;
    localparam int UART_FRAME_BITS      = 11;
    localparam int DEFAULT_FRAME_CYCLES = 9600;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } sender_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered level and combinational head read.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [LVL_W-1:0]  level_reg;
    logic              do_push;
    logic              do_pop;

    assign full     = (level_reg == LVL_W'(DEPTH));
    assign empty    = (level_reg == '0);
    assign level    = level_reg;
    assign pop_data = mem[rd_ptr_reg];
    // Flush wins over both ports so a discarded FIFO never leaks a byte.
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (do_push && !do_pop)
                level_reg <= level_reg + 1'b1;
            else if (do_pop && !do_push)
                level_reg <= level_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= push_data;
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin byte scheduler feeding a UART that has no busy flag; this block
// spaces write strobes by FRAME_CYCLES so a frame is never overwritten.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int FIFO_DEPTH   = 16,
    parameter int FRAME_CYCLES = DEFAULT_FRAME_CYCLES,
    parameter int LVL_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                      sys_clk_i,
    input  logic                      sys_rstn_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic                      flush_i,
    output logic                      uart_wr_o,
    output logic [BYTE_W-1:0]         uart_dat_o,
    output logic [LVL_W-1:0]          fifo_level_o,
    output logic                      busy_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(FRAME_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(FRAME_CYCLES - 2);

    logic [PTR_W-1:0]  rr_ptr_reg;
    logic [PTR_W-1:0]  grant_idx;
    logic              grant_found;
    logic              grant_en;
    logic [BYTE_W-1:0] push_data;

    logic              fifo_full;
    logic              fifo_empty;
    logic [LVL_W-1:0]  fifo_level;
    logic [BYTE_W-1:0] fifo_head;

    sender_state_e     state_reg;
    sender_state_e     state_next;
    logic [CNT_W-1:0]  gap_cnt_reg;
    logic [CNT_W-1:0]  gap_cnt_next;
    logic [BYTE_W-1:0] dat_reg;
    logic              pop;
    logic              can_pop;

    // First valid client at or after the pointer, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && req_valid_i[(int'(rr_ptr_reg) + k) % NUM_REQ]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'((int'(rr_ptr_reg) + k) % NUM_REQ);
            end
        end
    end

    // Fullness is the registered flag, so a same-cycle pop never frees a slot.
    assign grant_en  = grant_found && !fifo_full && !flush_i && sys_rstn_i;
    assign push_data = req_data_i[grant_idx*BYTE_W +: BYTE_W];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready_o[gi] = grant_en && (grant_idx == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i)
            rr_ptr_reg <= '0;
        else if (grant_en)
            rr_ptr_reg <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
    end

    sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk       (sys_clk_i),
        .rst_n     (sys_rstn_i),
        .flush     (flush_i),
        .push      (grant_en),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign can_pop = !fifo_empty && !flush_i;

    // Gap counter spans the rest of the frame after the SEND cycle.
    always_comb begin
        state_next   = state_reg;
        gap_cnt_next = gap_cnt_reg;
        pop          = 1'b0;
        case (state_reg)
            IDLE: begin
                if (can_pop) begin
                    pop        = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                gap_cnt_next = GAP_LOAD;
                state_next   = GAP;
            end
            GAP: begin
                if (gap_cnt_reg == '0) begin
                    if (can_pop) begin
                        pop        = 1'b1;
                        state_next = SEND;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    gap_cnt_next = gap_cnt_reg - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            state_reg   <= IDLE;
            gap_cnt_reg <= '0;
            dat_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            gap_cnt_reg <= gap_cnt_next;
            if (pop) dat_reg <= fifo_head;
        end
    end

    assign uart_wr_o    = (state_reg == SEND);
    assign uart_dat_o   = dat_reg;
    assign fifo_level_o = fifo_level;
    assign busy_o       = (state_reg != IDLE) || !fifo_empty;

endmodule
